// File: rtl/cdc_handshake_tx.sv
// Source side of a toggle req/ack handshake that moves one WIDTH-bit word into another clock domain.
// Optional one-entry skid buffer compiled in by the CDC_HANDSHAKE_TX_SKID_EN macro.
module cdc_handshake_tx #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_p,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             req_async,
    output logic [WIDTH-1:0] data_async,
    input  logic             ack_async,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             req_q, req_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             rdy_q, rdy_d;
    (* ASYNC_REG = "TRUE" *) logic ack_meta_q;
    (* ASYNC_REG = "TRUE" *) logic ack_sync_q;

`ifdef CDC_HANDSHAKE_TX_SKID_EN
    logic             pend_vld_q, pend_vld_d;
    logic [WIDTH-1:0] pend_data_q, pend_data_d;
`endif

    logic accept;
    logic ack_seen;

    assign accept   = in_valid && rdy_q;
    assign ack_seen = (state_q == WAIT_ACK) && (ack_sync_q == req_q);

    // The only logic that samples the far-domain acknowledge.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
        end else begin
            ack_meta_q <= ack_async;
            ack_sync_q <= ack_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
        end
    end

`ifdef CDC_HANDSHAKE_TX_SKID_EN
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            pend_vld_q  <= 1'b0;
            pend_data_q <= '0;
        end else begin
            pend_vld_q  <= pend_vld_d;
            pend_data_q <= pend_data_d;
        end
    end
`endif

    // Next-state logic; status outputs are registered from the next-state values
    // so they read exactly as the current-state decode would.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
`ifdef CDC_HANDSHAKE_TX_SKID_EN
        pend_vld_d  = pend_vld_q;
        pend_data_d = pend_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = in_data;
                    req_d   = ~req_q;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
`ifdef CDC_HANDSHAKE_TX_SKID_EN
                if (ack_seen) begin
                    if (pend_vld_q) begin
                        data_d     = pend_data_q;
                        req_d      = ~req_q;
                        pend_vld_d = 1'b0;
                    end else if (accept) begin
                        data_d = in_data;
                        req_d  = ~req_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (accept) begin
                    pend_data_d = in_data;
                    pend_vld_d  = 1'b1;
                end
`else
                if (ack_seen) begin
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

`ifdef CDC_HANDSHAKE_TX_SKID_EN
        rdy_d  = (state_d == IDLE) || !pend_vld_d;
        busy_d = (state_d == WAIT_ACK) || pend_vld_d;
`else
        rdy_d  = (state_d == IDLE);
        busy_d = (state_d == WAIT_ACK);
`endif
        // ack_meta_q is the next ack_sync_q value.
        done_d = (state_d == WAIT_ACK) && (ack_meta_q == req_d);
    end

    assign in_ready   = rdy_q;
    assign req_async  = req_q;
    assign data_async = data_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed and random-delay bench for cdc_handshake_tx with a loopback far-domain ack model.
module tb_cdc_handshake_tx;

    logic       clk = 1'b0;
    logic       rst_p;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       req_async;
    logic [7:0] data_async;
    logic       ack_async;
    logic       busy;
    logic       done;

    cdc_handshake_tx #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_p      (rst_p),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .req_async  (req_async),
        .data_async (data_async),
        .ack_async  (ack_async),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

`ifdef CDC_HANDSHAKE_TX_SKID_EN
    localparam logic RDY_WAIT = 1'b1;
`else
    localparam logic RDY_WAIT = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Far-domain model: ack follows req after a programmable number of clk edges.
    logic ack_q;
    int   ack_cnt;
    int   ack_rdly;
    int   ack_fix  = 3;
    bit   ack_rand = 1'b0;
    bit   ack_auto = 1'b1;
    logic ack_man  = 1'b0;
    int   ack_dly;

    assign ack_dly   = ack_rand ? ack_rdly : ack_fix;
    assign ack_async = ack_auto ? ack_q : ack_man;

    always @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            ack_q    <= 1'b0;
            ack_cnt  <= 0;
            ack_rdly <= 1;
        end else if (req_async != ack_q) begin
            if (ack_cnt >= ack_dly - 1) begin
                ack_q    <= req_async;
                ack_cnt  <= 0;
                ack_rdly <= int'($urandom_range(20, 1));
            end else begin
                ack_cnt <= ack_cnt + 1;
            end
        end
    end

    // Launch recorder and data-stability monitor.
    bit         mon_en = 1'b0;
    logic       prev_req;
    logic [7:0] prev_data;
    logic       prev_pend;
    logic [7:0] launches[$];
    logic [7:0] sent[$];
    int         viol = 0;
    int         done_cnt = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (req_async != prev_req) launches.push_back(data_async);
            else if (prev_pend && (data_async != prev_data)) viol++;
            if (done) done_cnt++;
        end
        prev_req  = req_async;
        prev_data = data_async;
        prev_pend = (req_async != ack_async);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_p    = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_p = 1'b0;
    endtask

    // Returns at the negedge just after the transfer edge.
    task automatic send(input logic [7:0] d);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_timeout", 32'(n), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    int lat;
    int n;
    int spur;
    logic [7:0] d;

    initial begin
        rst_p    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(negedge clk);
        chk("rst_req",   32'(req_async),  32'd0);
        chk("rst_data",  32'(data_async), 32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_done",  32'(done),       32'd0);
        chk("rst_ready", 32'(in_ready),   32'd0);
        rst_p = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        // Single launch of 0xA5, ack looped back 3 clk later
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(negedge clk);
        in_valid = 1'b0;
        chk("launch_req",   32'(req_async),  32'd1);
        chk("launch_data",  32'(data_async), 32'hA5);
        chk("launch_busy",  32'(busy),       32'd1);
        chk("launch_ready", 32'(in_ready),   32'(RDY_WAIT));
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("done_latency", 32'(lat), 32'd5);
        chk("ready_at_done", 32'(in_ready), 32'(RDY_WAIT));
        @(negedge clk);
        chk("done_one_cycle", 32'(done),     32'd0);
        chk("ready_after",    32'(in_ready), 32'd1);
        chk("busy_after",     32'(busy),     32'd0);

        // Spurious ack toggle while idle
        ack_man  = ack_q;
        ack_auto = 1'b0;
        ack_man  = ~ack_man;
        spur = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) spur++;
        end
        chk("spur_done",  32'(spur),      32'd0);
        chk("spur_req",   32'(req_async), 32'd1);
        chk("spur_busy",  32'(busy),      32'd0);
        chk("spur_ready", 32'(in_ready),  32'd1);
        ack_man = ~ack_man;
        repeat (4) @(negedge clk);
        ack_auto = 1'b1;

`ifdef CDC_HANDSHAKE_TX_SKID_EN
        // Back-to-back 0x11/0x22/0x33 with ack held off
        launches.delete();
        done_cnt = 0;
        mon_en   = 1'b1;
        ack_man  = req_async;
        ack_auto = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h11;
        @(negedge clk);
        chk("skid_ready_1", 32'(in_ready), 32'd1);
        in_data = 8'h22;
        @(negedge clk);
        in_data = 8'h33;
        chk("skid_ready_full", 32'(in_ready),   32'd0);
        chk("skid_data_11",    32'(data_async), 32'h11);
        repeat (3) @(negedge clk);
        chk("skid_stall", 32'(in_ready), 32'd0);
        ack_man = req_async;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("skid_data_22", 32'(data_async), 32'h22);
        @(negedge clk);
        in_valid = 1'b0;
        ack_man  = req_async;
        n = 0;
        while (data_async != 8'h33 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ack_man = req_async;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        mon_en = 1'b0;
        chk("skid_launch_cnt", 32'(launches.size()), 32'd3);
        chk("skid_seq0", 32'(launches[0]), 32'h11);
        chk("skid_seq1", 32'(launches[1]), 32'h22);
        chk("skid_seq2", 32'(launches[2]), 32'h33);
        chk("skid_done_cnt", 32'(done_cnt), 32'd3);
        ack_auto = 1'b1;
`endif

        // Reset one cycle after launching 0x5A
        do_reset();
        send(8'h5A);
        chk("pre_rst_data", 32'(data_async), 32'h5A);
        rst_p = 1'b1;
        #1;
        chk("midrst_req",   32'(req_async),  32'd0);
        chk("midrst_data",  32'(data_async), 32'd0);
        chk("midrst_busy",  32'(busy),       32'd0);
        chk("midrst_ready", 32'(in_ready),   32'd0);
        @(negedge clk);
        rst_p = 1'b0;
        send(8'h3C);
        chk("relaunch_req",  32'(req_async),  32'd1);
        chk("relaunch_data", 32'(data_async), 32'h3C);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("relaunch_latency", 32'(lat), 32'd5);
        repeat (2) @(negedge clk);

        // 1000 words with random ack delay 1..20
        launches.delete();
        sent.delete();
        done_cnt = 0;
        viol     = 0;
        ack_rand = 1'b1;
        mon_en   = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            d = 8'($urandom);
            sent.push_back(d);
            send(d);
        end
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        mon_en = 1'b0;
        chk("rand_drain", 32'(busy), 32'd0);
        chk("rand_launch_cnt", 32'(launches.size()), 32'd1000);
        for (int i = 0; i < 1000; i++) begin
            chk($sformatf("rand_word%0d", i), 32'(launches[i]), 32'(sent[i]));
        end
        chk("rand_done_cnt", 32'(done_cnt), 32'd1000);
        chk("rand_stable",   32'(viol),     32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdc_handshake_tx.md
CDC_HANDSHAKE_TX -- requirements
Module: cdc_handshake_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the transferred data word width in bits.
REQ-002 SHALL have port clk  input  1  source-domain clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_p  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  source offers in_data this cycle.
REQ-005 SHALL have port in_ready  output  1  block accepts in_data this cycle; a transfer occurs on a rising edge where in_valid and in_ready are both 1.
REQ-006 SHALL have port in_data  input  WIDTH  word to send.
REQ-007 SHALL have port req_async  output  1  toggle request to the far domain, driven directly from a flop.
REQ-008 SHALL have port data_async  output  WIDTH  launched word, driven directly from flops.
REQ-009 SHALL have port ack_async  input  1  toggle acknowledge from the far domain, asynchronous to clk.
REQ-010 SHALL have port busy  output  1  a word is in flight or held in the skid buffer.
REQ-011 SHALL have port done  output  1  one-cycle pulse when an in-flight word is acknowledged.

Function
REQ-012 SHALL pass ack_async through a two-flop synchronizer (ack_meta, then ack_sync), both flops marked ASYNC_REG; no other logic SHALL sample ack_async.
REQ-013 SHALL implement states IDLE and WAIT_ACK.
REQ-014 In IDLE, on an accepted transfer: data_async <= in_data, req_async <= ~req_async, state <= WAIT_ACK, all on the same edge.
REQ-015 SHALL hold data_async constant for as long as ack_sync != req_async.
REQ-016 In WAIT_ACK, acknowledge is detected when ack_sync == req_async; done SHALL be 1 in exactly that cycle.
REQ-017 On acknowledge with no further word available: state <= IDLE on that edge.
REQ-018 SHALL keep the number of req_async toggles minus ack_async toggles within 0..1; no new launch while unacknowledged.
REQ-019 Minimum latency from launch edge to done: 2 clk cycles after ack_async toggles (synchronizer depth).
REQ-020 busy SHALL equal (state == WAIT_ACK) or pend_vld.
REQ-021 An ack_async toggle arriving in IDLE (spurious) SHALL be ignored: no state change, no done pulse.

Reset
REQ-022 While rst_p is 1: state = IDLE, req_async = 0, data_async = 0, ack_meta = ack_sync = 0, pend_vld = 0, done = 0, busy = 0.
REQ-023 in_ready SHALL be 0 while rst_p is 1 and 1 from the first clk edge after release.
REQ-024 Reset asserted mid-transfer SHALL abandon the in-flight and pending words; the far-domain receiver is reset by the same reset.

Configuration
REQ-025 Macro CDC_HANDSHAKE_TX_SKID_EN compiles in a one-entry skid register (pend_data, pend_vld).
REQ-026 Without the macro: in_ready = (state == IDLE); there is no pend storage; pend_vld is constant 0.
REQ-027 With the macro: in_ready = (state == IDLE) or not pend_vld. In WAIT_ACK an accepted word is stored into pend_data and pend_vld <= 1.
REQ-028 With the macro, the acknowledge edge SHALL select in priority order:
  (a) if pend_vld, launch pend_data and clear pend_vld;
  (b) else if a word is accepted in that same cycle, launch it directly;
  (c) else go to IDLE.
  Cases (a) and (b) remain in WAIT_ACK and toggle req_async.

Verification
REQ-029 Reset, then in_valid=1 with in_data=0xA5 for one cycle -> next cycle req_async=1, data_async=0xA5, busy=1, in_ready=0 (macro off).
REQ-030 Loopback with ack_async = req_async delayed 3 clk -> done pulses exactly 5 cycles after launch; in_ready returns 1 on the following cycle.
REQ-031 Macro on: send 0x11, 0x22, 0x33 back-to-back while ack is held off ->
  - 0x11 is launched and 0x22 is held in pend;
  - 0x33 is stalled with in_ready=0;
  - after acks, data_async sequence is 0x11, 0x22, 0x33, each with exactly one req toggle.
REQ-032 Toggle ack_async while in IDLE -> no done pulse, state stays IDLE, req_async unchanged.
REQ-033 Assert rst_p 1 cycle after launching 0x5A -> req_async=0, data_async=0x00, busy=0 asynchronously; the next accepted word launches normally.
REQ-034 Random ack delays of 1..20 cycles, 1000 words -> no word lost or duplicated, and data_async never changes while a request is unacknowledged.
